serv_dbus_bridge: RTL and testbench
===================================

Name: serv_dbus_bridge

Overview:
Data-bus sequencer between the bit-serial core's data buffer register and a Wishbone-classic data port.
- Issues one load or store transaction per request.
- Stores: derives byte selects from address LSBs and access size; takes write data straight from the buffer register output.
- Loads: captures read data and hands it back to the buffer register with a one-cycle load strobe.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: cycles to wait for i_wb_ack before aborting; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  1  single-cycle request pulse from core control
- i_we  in  1  1=store, 0=load; sampled with i_req
- i_word  in  1  word access; sampled with i_req
- i_half  in  1  halfword access (byte if neither i_word nor i_half); sampled with i_req
- i_adr  in  32  byte address; sampled with i_req
- i_wdat  in  32  store data, already lane-positioned by buffer register
- o_wb_adr  out  32  word-aligned address {adr[31:2],2'b00}
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte lane enables
- o_wb_we  out  1  write enable
- o_wb_cyc  out  1  cycle/strobe (stb tied to cyc externally)
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  transfer acknowledge
- o_load  out  1  one-cycle strobe: load o_rdt into buffer register
- o_rdt  out  32  registered read data
- o_ack  out  1  one-cycle completion pulse to core
- o_misalign  out  1  qualifies o_ack: access was misaligned, no bus cycle issued
- o_err  out  1  qualifies o_ack: bus timeout
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, BUS, RESP. All outputs are registered.
- Reset: state=IDLE; o_wb_cyc, o_wb_we, o_load, o_ack, o_misalign, o_err = 0; o_wb_sel=0; o_rdt=0; counter=0. o_wb_adr and o_wb_dat are don't-care at reset.
- Misalignment:
  - misaligned = (i_word & |i_adr[1:0]) | (i_half & i_adr[0]).
  - Byte accesses are never misaligned.
- Lane selects:
  - word: 4'b1111
  - half: adr[1] ? 4'b1100 : 4'b0011
  - byte: 4'b0001 << adr[1:0]
- IDLE, i_req=1 and misaligned:
  - No bus cycle.
  - Next cycle: o_ack=1, o_misalign=1 for one cycle.
  - Stays IDLE.
- IDLE, i_req=1 and aligned:
  - Next edge latches adr, sel, we, and i_wdat into o_wb_dat.
  - o_wb_cyc=1, counter=0, go to BUS.
  - Request-to-cyc latency is 1 cycle.
- BUS, i_wb_ack=1:
  - o_wb_cyc=0 on next edge; go to RESP.
  - Load: o_rdt <= i_wb_rdt.
- RESP (exactly one cycle):
  - o_ack=1.
  - o_load = ~we; o_load and o_ack are coincident.
  - Return to IDLE.
  - Minimum ack-to-o_ack latency: 1 cycle.
- BUS, no ack, TIMEOUT!=0:
  - counter increments each cycle.
  - When counter==TIMEOUT-1 and no ack: o_wb_cyc=0 next edge; next cycle o_ack=1, o_err=1, o_load=0; return to IDLE.
- Ack in the same cycle as timeout expiry: ack wins, normal completion, o_err=0.
- i_req while not IDLE: ignored, no queueing. Core must not pulse before o_ack.
- i_wb_ack while not BUS: ignored.
- i_rst asserted mid-transaction:
  - o_wb_cyc drops on that edge.
  - No o_ack for the aborted access.
- o_wb_dat, o_wb_adr, o_wb_sel, o_wb_we stay stable for the whole of BUS.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, BUS=2'd1, RESP=2'd2);
  - lane-select function/constants (SEL_WORD, SEL_HALF_LO, SEL_HALF_HI).
- One natural sub-module: serv_dbus_timeout, the counter with enable/clear and an expiry output. It is removed entirely when TIMEOUT=0.

Test Plan:
- Word store adr=0x1000_0004, wdat=0xDEADBEEF, ack after 3 cycles:
  - cyc high 1 cycle after req; sel=1111, we=1, adr=0x1000_0004.
  - o_ack pulse 1 cycle after ack; o_load=0.
- Byte load adr=0x2003, i_wb_rdt=0xA1B2C3D4, ack after 1 cycle:
  - sel=1000, adr=0x2000.
  - o_rdt=0xA1B2C3D4, and o_load and o_ack high in the same single cycle.
- Half load adr=0x2001:
  - cyc never rises.
  - o_ack=1 and o_misalign=1 one cycle after req; o_load=0.
- TIMEOUT=4, no ack:
  - cyc high exactly 4 cycles.
  - Then o_ack=1, o_err=1; next req accepted normally.
- Ack on the final timeout cycle returns data, o_err=0. A second req pulse during BUS is ignored: exactly one o_ack.
- i_rst during BUS (cycle 2): cyc=0 next edge, no o_ack, o_busy=0; subsequent word load completes normally.

Source files
------------

// File: rtl/serv_dbus_bridge_pkg.sv
// serv_dbus_bridge_pkg: shared FSM encoding and lane-select helpers for the data-bus bridge
//   state_t        : IDLE / BUS / RESP encoding
//   SEL_*          : byte-lane enable constants
//   misaligned()   : access crosses its natural alignment
//   lane_sel()     : byte-lane enables from access size and address LSBs
package serv_dbus_bridge_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;
   localparam logic [3:0] SEL_WORD    = 4'b1111;
   localparam logic [3:0] SEL_HALF_LO = 4'b0011;
   localparam logic [3:0] SEL_HALF_HI = 4'b1100;
   function automatic logic misaligned(input logic word, input logic half, input logic [1:0] lsb);
      return (word & |lsb) | (half & lsb[0]);
   endfunction
   function automatic logic [3:0] lane_sel(input logic word, input logic half, input logic [1:0] lsb);
      return word ? SEL_WORD : half ? (lsb[1] ? SEL_HALF_HI : SEL_HALF_LO) : 4'(4'b0001 << lsb);
   endfunction
endpackage

// File: rtl/serv_dbus_timeout.sv
// serv_dbus_timeout: bus-cycle watchdog counter
//   clk, rst : clock, synchronous active-high reset
//   clr      : hold counter at zero (outside a bus cycle)
//   en       : count one waiting cycle
//   expired  : counter has reached TIMEOUT-1 (last cycle to wait)
module serv_dbus_timeout #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [TO_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
   assign expired = cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/serv_dbus_bridge.sv
// serv_dbus_bridge: sequences one Wishbone-classic load/store per core request
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req/i_we/i_word/i_half/i_adr/i_wdat : request and its attributes
//   o_wb_* / i_wb_rdt / i_wb_ack          : Wishbone data port (stb tied to cyc)
//   o_load, o_rdt         : read-data hand-back to the buffer register
//   o_ack, o_misalign, o_err, o_busy      : completion and status to the core
module serv_dbus_bridge
   import serv_dbus_bridge_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic        i_word,
   input  logic        i_half,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_wdat,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_load,
   output logic [31:0] o_rdt,
   output logic        o_ack,
   output logic        o_misalign,
   output logic        o_err,
   output logic        o_busy
);
   state_t state;
   logic   expired;
   generate
      if (TIMEOUT != 0) begin : g_to
         serv_dbus_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
            .clk(i_clk),
            .rst(i_rst),
            .clr(state != BUS),
            .en(state == BUS && !i_wb_ack),
            .expired(expired)
         );
      end else begin : g_no_to
         assign expired = 1'b0;
      end
   endgenerate
   // Completion strobes are raised on the edge that enters RESP (or on the
   // rejecting edge for misalignment) so they are high for exactly one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         o_wb_cyc   <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_sel   <= '0;
         o_load     <= 1'b0;
         o_ack      <= 1'b0;
         o_misalign <= 1'b0;
         o_err      <= 1'b0;
         o_rdt      <= '0;
         o_busy     <= 1'b0;
      end else begin
         o_ack      <= 1'b0;
         o_load     <= 1'b0;
         o_misalign <= 1'b0;
         o_err      <= 1'b0;
         case (state)
            IDLE: if (i_req) begin
               if (misaligned(i_word, i_half, i_adr[1:0])) begin
                  o_ack      <= 1'b1;
                  o_misalign <= 1'b1;
               end else begin
                  o_wb_adr <= {i_adr[31:2], 2'b00};
                  o_wb_dat <= i_wdat;
                  o_wb_sel <= lane_sel(i_word, i_half, i_adr[1:0]);
                  o_wb_we  <= i_we;
                  o_wb_cyc <= 1'b1;
                  o_busy   <= 1'b1;
                  state    <= BUS;
               end
            end
            BUS: if (i_wb_ack) begin
               o_wb_cyc <= 1'b0;
               o_ack    <= 1'b1;
               o_load   <= ~o_wb_we;
               if (!o_wb_we) o_rdt <= i_wb_rdt;
               state    <= RESP;
            end else if (expired) begin
               o_wb_cyc <= 1'b0;
               o_ack    <= 1'b1;
               o_err    <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_wb_cyc <= 1'b0;
               o_busy   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serv_dbus_bridge.sv
// tb_serv_dbus_bridge: randomized transaction-level bench for serv_dbus_bridge
module tb_serv_dbus_bridge;
   localparam int TO = 4;
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, word = 1'b0, half = 1'b0, wb_ack = 1'b0;
   logic [31:0] adr = '0, wdat = '0, wb_rdt = '0;
   logic [31:0] wb_adr, wb_dat, rdt;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, load, ack, misalign, err, busy;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] exp_rdt = '0;

   serv_dbus_bridge #(.TIMEOUT(TO), .TO_W(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_word(word), .i_half(half),
      .i_adr(adr), .i_wdat(wdat), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
      .o_wb_we(wb_we), .o_wb_cyc(wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
      .o_load(load), .o_rdt(rdt), .o_ack(ack), .o_misalign(misalign), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit exp_mis(input bit w, input bit h, input logic [31:0] a);
      if (w) return (a % 4) != 0;
      if (h) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_sel(input bit w, input bit h, input logic [31:0] a);
      int b;
      b = int'(a % 4);
      if (w) return 4'hf;
      if (h) return (b >= 2) ? 4'hc : 4'h3;
      return 4'(2 ** b);
   endfunction

   // d: index of the bus cycle in which the slave acks (>= TO means never in time)
   task automatic txn(input bit t_we, input bit t_word, input bit t_half, input logic [31:0] t_adr,
                      input logic [31:0] t_wdat, input logic [31:0] t_rdat, input int d,
                      input bit rst_mid, input bit extra_req);
      bit          mis, to_exp;
      int          n, exp_n;
      logic [31:0] e_adr;
      logic [3:0]  e_sel;
      mis   = exp_mis(t_word, t_half, t_adr);
      e_adr = t_adr & 32'hffff_fffc;
      e_sel = exp_sel(t_word, t_half, t_adr);
      req = 1'b1; we = t_we; word = t_word; half = t_half; adr = t_adr; wdat = t_wdat;
      @(posedge clk); #1;
      req = 1'b0; adr = $urandom; wdat = $urandom; we = ~t_we;
      if (mis) begin
         check("mis_cyc", 32'(wb_cyc), 0);
         check("mis_ack", 32'(ack), 1);
         check("mis_flag", 32'(misalign), 1);
         check("mis_load", 32'(load), 0);
         check("mis_err", 32'(err), 0);
         check("mis_busy", 32'(busy), 0);
         @(posedge clk); #1;
         check("mis_ack_clr", 32'(ack), 0);
         check("mis_cyc_late", 32'(wb_cyc), 0);
         return;
      end
      check("req_cyc", 32'(wb_cyc), 1);
      check("req_busy", 32'(busy), 1);
      n = 0;
      while (wb_cyc && n < 20) begin
         check("bus_adr", wb_adr, e_adr);
         check("bus_sel", 32'(wb_sel), 32'(e_sel));
         check("bus_we", 32'(wb_we), 32'(t_we));
         check("bus_dat", wb_dat, t_wdat);
         check("bus_no_ack", 32'(ack), 0);
         if (rst_mid && n == 1) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_rdt = '0;
            check("rst_cyc", 32'(wb_cyc), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_ack", 32'(ack), 0);
            check("rst_rdt", rdt, exp_rdt);
            repeat (3) begin
               @(posedge clk); #1;
               check("rst_no_ack", 32'(ack), 0);
               check("rst_no_cyc", 32'(wb_cyc), 0);
            end
            return;
         end
         wb_ack = (n == d);
         wb_rdt = (n == d) ? t_rdat : $urandom;
         if (extra_req && n == 1) begin
            req = 1'b1; word = 1'b1; half = 1'b0; adr = $urandom & 32'hffff_fffc;
         end
         @(posedge clk); #1;
         wb_ack = 1'b0; req = 1'b0; wb_rdt = $urandom;
         n++;
      end
      exp_n  = (d < TO) ? d + 1 : TO;
      to_exp = d >= TO;
      check("cyc_len", 32'(n), 32'(exp_n));
      check("done_ack", 32'(ack), 1);
      check("done_err", 32'(err), 32'(to_exp));
      check("done_mis", 32'(misalign), 0);
      check("done_load", 32'(load), 32'(!t_we && !to_exp));
      if (!t_we && !to_exp) exp_rdt = t_rdat;
      check("done_rdt", rdt, exp_rdt);
      check("done_busy", 32'(busy), 1);
      @(posedge clk); #1;
      check("post_ack", 32'(ack), 0);
      check("post_load", 32'(load), 0);
      check("post_busy", 32'(busy), 0);
      check("post_cyc", 32'(wb_cyc), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_cyc0", 32'(wb_cyc), 0);
      check("rst_ack0", 32'(ack), 0);
      check("rst_sel0", 32'(wb_sel), 0);
      check("rst_rdt0", rdt, 0);
      check("rst_load0", 32'(load), 0);
      check("rst_mis0", 32'(misalign), 0);
      check("rst_err0", 32'(err), 0);
      check("rst_busy0", 32'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      txn(1, 1, 0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 2, 0, 0);
      txn(0, 0, 0, 32'h0000_2003, 32'h0, 32'hA1B2_C3D4, 0, 0, 0);
      txn(0, 0, 1, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 0);
      txn(1, 1, 0, 32'h0000_3000, 32'h1234_5678, 32'h0, 9, 0, 0);
      txn(0, 1, 0, 32'h0000_3004, 32'h0, 32'h5566_7788, 1, 0, 0);
      txn(0, 0, 1, 32'h0000_4002, 32'h0, 32'hCAFE_F00D, TO - 1, 0, 1);
      txn(1, 0, 1, 32'h0000_5000, 32'hAAAA_5555, 32'h0, 5, 1, 0);
      txn(0, 1, 0, 32'h0000_6008, 32'h0, 32'h0BAD_F00D, 1, 0, 0);
      for (int i = 0; i < 80; i++) begin
         int sz;
         sz = int'($urandom_range(0, 2));
         txn(1'($urandom), sz == 2, sz == 1, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)), 0, $urandom_range(0, 3) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
